wave_load_sched: RTL

WAVE_LOAD_SCHED -- requirements
Module: wave_load_sched

---
 rtl/wave_load_sched_pkg.sv | 30 +++
 rtl/wave_load_sched_fifo.sv | 61 ++++++
 rtl/wave_load_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wave_load_sched_pkg.sv
// Shared mode codes and scheduler state encoding
// for the waveform load scheduler.
package wave_load_sched_pkg;

  localparam logic [7:0] MODE_IDLE            = 8'd0;
  localparam logic [7:0] MODE_SET_CH_WAVEFORM = 8'd1;
  localparam logic [7:0] MODE_CMD_ARM         = 8'd5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_T = 3'd1;
  localparam logic [2:0] ST_LOAD_V = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_ARMED  = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;

  function automatic logic [7:0] mode_of(input logic [2:0] st);
    logic [7:0] m;
    m = MODE_IDLE;
    case (st)
      ST_LOAD_T,
      ST_LOAD_V,
      ST_GAP:   m = MODE_SET_CH_WAVEFORM;
      ST_ARMED,
      ST_RUN:   m = MODE_CMD_ARM;
      default:  m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wave_load_sched_fifo.sv
// Entry FIFO for the load scheduler: registered storage,
// pointer + count, no write-to-read bypass.
module sched_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         one_left
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign one_left = (count == ONE_CNT);
  assign do_wr    = wr_en && !full && !flush;
  assign do_rd    = rd_en && !empty && !flush;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wave_load_sched.sv
// Waveform load scheduler: streams FIFO entries to the
// generator in 3-cycle triplets, then arms and runs on trigger.
module wave_load_sched #(
  parameter int BIT_NUM = 32,
  parameter int DEPTH   = 16
) (
  input  logic               iCLK,
  input  logic               iNRST,
  input  logic               iWR_VALID,
  input  logic [7:0]         iWR_CHANNEL,
  input  logic [BIT_NUM-1:0] iWR_TIME,
  input  logic               iWR_VAL,
  input  logic               iCMD_ARM,
  input  logic               iCMD_ABORT,
  input  logic [BIT_NUM-1:0] iPERIOD,
  input  logic               iTRIG,
  output logic [7:0]         oMODE,
  output logic               oFLAG_TIME_READY,
  output logic               oFLAG_CH_VAL_READY,
  output logic [7:0]         oDATA_CHANNEL,
  output logic [BIT_NUM-1:0] oDATA_TIME,
  output logic               oDATA_CH_VAL,
  output logic               oFULL,
  output logic               oOVERFLOW,
  output logic               oARMED,
  output logic               oRUNNING,
  output logic               oTRIG_SYNC,
  output logic               oOUTPUT_CLK_RESET,
  output logic               oDONE
);

  import wave_load_sched_pkg::*;

  localparam int EW = 8 + BIT_NUM + 1;
  localparam logic [BIT_NUM-1:0] ONE = BIT_NUM'(1);

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic               arm_pending_q;
  logic               overflow_q;
  logic [2:0]         trig_sync_q;
  logic               trig_pulse_q;
  logic [BIT_NUM-1:0] cnt_q;
  logic [BIT_NUM-1:0] period_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_one;
  logic [EW-1:0] head;

  logic busy;
  logic wr_accept;
  logic pop;
  logic arm_req;
  logic more;
  logic trig_edge;
  logic trig_go;
  logic run_last;
  logic load_phase;

  assign busy      = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign wr_accept = iWR_VALID && !fifo_full && !busy && !iCMD_ABORT;
  assign pop       = (state_q == ST_GAP) && !iCMD_ABORT;
  assign arm_req   = arm_pending_q || iCMD_ARM;
  assign more      = !fifo_one || wr_accept;
  assign trig_edge = trig_sync_q[1] && !trig_sync_q[2];
  assign trig_go   = (state_q == ST_ARMED) && trig_edge;
  assign run_last  = (cnt_q == period_q - ONE);

  sched_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (iCLK),
    .rst_n    (iNRST),
    .flush    (iCMD_ABORT),
    .wr_en    (wr_accept),
    .rd_en    (pop),
    .wr_data  ({iWR_CHANNEL, iWR_TIME, iWR_VAL}),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one)
  );

  // Loading waits while a write burst is in progress in IDLE.
  always_comb begin
    state_d = state_q;
    if (iCMD_ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iWR_VALID)        state_d = ST_IDLE;
          else if (!fifo_empty) state_d = ST_LOAD_T;
          else if (arm_req)     state_d = ST_ARMED;
        end
        ST_LOAD_T: state_d = ST_LOAD_V;
        ST_LOAD_V: state_d = ST_GAP;
        ST_GAP: begin
          if (more)         state_d = ST_LOAD_T;
          else if (arm_req) state_d = ST_ARMED;
          else              state_d = ST_IDLE;
        end
        ST_ARMED: if (trig_edge) state_d = ST_RUN;
        ST_RUN:   if (run_last)  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iNRST) begin
    if (!iNRST) begin
      state_q       <= ST_IDLE;
      arm_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (iCMD_ABORT || state_d == ST_ARMED)
        arm_pending_q <= 1'b0;
      else if (iCMD_ARM && !busy)
        arm_pending_q <= 1'b1;
      if (iCMD_ABORT)
        overflow_q <= 1'b0;
      else if (iWR_VALID && !wr_accept)
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iNRST) begin
    if (!iNRST) begin
      trig_sync_q  <= '0;
      trig_pulse_q <= 1'b0;
      cnt_q        <= '0;
      period_q     <= ONE;
    end else begin
      trig_sync_q  <= {trig_sync_q[1:0], iTRIG};
      trig_pulse_q <= trig_go && !iCMD_ABORT;
      if (trig_go && !iCMD_ABORT) begin
        cnt_q    <= '0;
        period_q <= (iPERIOD == '0) ? ONE : iPERIOD;
      end else if (state_q == ST_RUN) begin
        cnt_q <= cnt_q + ONE;
      end
    end
  end

  assign load_phase = (state_q == ST_LOAD_T) || (state_q == ST_LOAD_V);

  assign oMODE              = mode_of(state_q);
  assign oFLAG_TIME_READY   = (state_q == ST_LOAD_T);
  assign oFLAG_CH_VAL_READY = (state_q == ST_LOAD_V);
  assign {oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL} =
    load_phase ? head : '0;
  assign oFULL              = fifo_full;
  assign oOVERFLOW          = overflow_q;
  assign oARMED             = (state_q == ST_ARMED);
  assign oRUNNING           = (state_q == ST_RUN);
  assign oTRIG_SYNC         = trig_pulse_q;
  assign oOUTPUT_CLK_RESET  = trig_pulse_q;
  assign oDONE = (state_q == ST_RUN) && run_last && !iCMD_ABORT;

endmodule
